permutation_xor_unrolled: RTL and testbench
===========================================

Name: permutation_xor_unrolled

Overview:
- Parametrised ASCON permutation engine with an owned state register and an internal round counter driven by a start/done handshake.
- Applies UNROLL rounds per clock and supports 6-, 8- or 12-round permutations selected per operation.
- Also supports a zero-round XOR-only update.
- Optional 128-bit XOR on S[0]||S[1] before the first round; optional 192-bit XOR on S[2]||S[3]||S[4] after the last round.
- Sits between the AEAD control FSM and the round datapath (constant add, substitution, diffusion).

Parameters:
- UNROLL, 1, rounds computed per clock; legal values are 1, 2, 3, 4 and 6.
- RST_STATE, 320'h0, state register value after reset.

Ports:
- clock_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  operation request; accepted when start_i && ready_o
- nrounds_i  in  4  round count for this operation; legal values 0, 6, 8, 12
- init_state_i  in  1  1: source state is S_i; 0: source state is the internal register
- S_i  in  type_state (5x64)  external state; S_i[0] is word x0
- ctrl_1_i  in  1  enable the pre-permutation XOR
- data_1_i  in  128  pre-XOR data; [127:64] goes to S[0], [63:0] goes to S[1]
- ctrl_2_i  in  1  enable the post-permutation XOR
- data_2_i  in  192  post-XOR data; [191:128] goes to S[2], [127:64] to S[3], [63:0] to S[4]
- ready_o  out  1  engine idle and able to accept start_i
- done_o  out  1  one-cycle pulse; state_o is final
- err_o  out  1  one-cycle pulse on an illegal request
- state_o  out  type_state  current state register contents
- cipher_o  out  128  {S[0],S[1]} of the state register
- tag_o  out  128  {S[3],S[4]} of the state register

Behaviour:
- Reset (rst_i=1 at clock edge):
  - state register = RST_STATE; FSM = IDLE.
  - ready_o=1, done_o=0, err_o=0, round counter=0.
  - Reset overrides everything and aborts any operation in progress; no done_o is issued for the aborted operation.
- FSM states: IDLE, RUN.
- IDLE, ready_o=1:
  - Legal accept means nrounds_i is in {6,8,12} and divisible by UNROLL, or nrounds_i=0.
  - Otherwise the request is illegal: err_o=1 next cycle; state unchanged; FSM stays IDLE.
- On a legal accept:
  - Latch ctrl_2_i and data_2_i, and load round counter r = 12 - nrounds_i.
  - Source = init_state_i ? S_i : state register. Apply the pre-XOR to the source if ctrl_1_i.
  - nrounds_i=0: apply the post-XOR if ctrl_2_i; write the result; done_o=1 next cycle; stay IDLE.
  - nrounds_i>0: apply rounds r .. r+UNROLL-1; write the result; r += UNROLL.
  - If r reaches 12 at this point, the write also includes the post-XOR and done_o=1 next cycle; stay IDLE. Otherwise go to RUN.
- RUN, ready_o=0:
  - Each cycle apply UNROLL rounds to the state register; r += UNROLL.
  - On the cycle r reaches 12: apply the post-XOR (latched value) in the same write; done_o=1 next cycle; return to IDLE.
  - start_i is ignored while in RUN: no err_o, not queued.
- Per-round operations:
  - Round constant for index r: c = {4'(15-r), 4'(r)}, XORed into S[2][7:0].
  - Then 5-bit S-box substitution, then linear diffusion, exactly as the existing constant_add, substitution and diffusion blocks.
- Latency: accept to done_o = nrounds_i/UNROLL cycles (1 cycle for nrounds_i=0).
  - When done_o is high, state_o, cipher_o and tag_o hold the final value. They stay stable until the next accepted start or reset.
- ready_o returns to 1 in the same cycle done_o rises, so back-to-back starts are allowed.
  - A start accepted in the done_o cycle with init_state_i=0 consumes the just-finished state.
- All outputs are registered or decoded directly from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- UNROLL=1, init_state_i=1, S_i = ASCON-AEAD128 init state (IV 0x00001000808C0001, K=0, N=0), nrounds_i=12, ctrl_2_i=1, data_2_i={64'h0,K} -> done_o exactly 12 cycles after accept. state_o matches the team C model bit-exact.
- Same stimulus with UNROLL=2, 3, 4 and 6 -> identical state_o; latency 6, 4, 3 and 2 cycles respectively.
- UNROLL=1, nrounds_i=8, ctrl_1_i=1, data_1_i=128'h0123456789ABCDEF_FEDCBA9876543210, init_state_i=0 -> pre-XOR applied only in the first cycle; done_o after 8 cycles; result matches the model.
- nrounds_i=0, ctrl_1_i=1, ctrl_2_i=0 -> after 1 cycle cipher_o = previous {S0,S1} XOR data_1_i; S[2..4] unchanged; done_o=1.
- UNROLL=4, nrounds_i=6 -> err_o pulse, state unchanged, ready_o stays 1. Also nrounds_i=5 with any UNROLL -> err_o.
- rst_i=1 asserted in the middle of a 12-round run (cycle 5) -> next cycle state_o=0, ready_o=1, no done_o. A start_i pulse during RUN is ignored and the run finishes at the original cycle count.

Source files
------------

// File: rtl/permutation_xor_unrolled.sv
// ASCON permutation engine: UNROLL rounds per clock over an owned 320-bit state,
// with an optional pre-XOR on S0||S1 and an optional post-XOR on S2||S3||S4.
module permutation_xor_unrolled #(
   parameter int unsigned  UNROLL    = 1,
   parameter logic [319:0] RST_STATE = 320'h0
) (
   input  logic             clock_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       nrounds_i,
   input  logic             init_state_i,
   input  logic [4:0][63:0] S_i,
   input  logic             ctrl_1_i,
   input  logic [127:0]     data_1_i,
   input  logic             ctrl_2_i,
   input  logic [191:0]     data_2_i,
   output logic             ready_o,
   output logic             done_o,
   output logic             err_o,
   output logic [4:0][63:0] state_o,
   output logic [127:0]     cipher_o,
   output logic [127:0]     tag_o
);

   typedef logic [4:0][63:0] state_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_t;

   localparam logic OK6  = ((6 % UNROLL) == 0);
   localparam logic OK8  = ((8 % UNROLL) == 0);
   localparam logic OK12 = ((12 % UNROLL) == 0);

   function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   // One round: constant addition, bitsliced 5-bit S-box, linear diffusion.
   function automatic state_t ascon_round(input state_t s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      state_t o;
      x0 = s[0];
      x1 = s[1];
      x2 = s[2] ^ {56'h0, 4'd15 - r, r};
      x3 = s[3];
      x4 = s[4];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return o;
   endfunction

   function automatic state_t post_xor(input state_t s, input logic en, input logic [191:0] d);
      state_t o;
      o    = s;
      o[2] = s[2] ^ (en ? d[191:128] : 64'h0);
      o[3] = s[3] ^ (en ? d[127:64]  : 64'h0);
      o[4] = s[4] ^ (en ? d[63:0]    : 64'h0);
      return o;
   endfunction

   fsm_t         fsm_r;
   state_t       state_r;
   logic [3:0]   round_r;
   logic         ctrl2_r;
   logic [191:0] data2_r;
   logic         done_r;
   logic         err_r;

   logic         idle_s;
   logic         legal_s;
   state_t       src_s;
   state_t       rnd_in_s;
   state_t       rnd_out_s;
   state_t       zero_res_s;
   state_t       round_res_s;
   logic [3:0]   r_start_s;
   logic [4:0]   r_next_s;
   logic         last_s;
   logic         post_en_s;
   logic [191:0] post_data_s;

   // Request decode and source-state selection with the optional pre-XOR.
   always_comb begin
      idle_s   = (fsm_r == ST_IDLE);
      legal_s  = (nrounds_i == 4'd0) ||
                 ((nrounds_i == 4'd6)  && OK6) ||
                 ((nrounds_i == 4'd8)  && OK8) ||
                 ((nrounds_i == 4'd12) && OK12);
      src_s    = init_state_i ? S_i : state_r;
      src_s[0] = src_s[0] ^ (ctrl_1_i ? data_1_i[127:64] : 64'h0);
      src_s[1] = src_s[1] ^ (ctrl_1_i ? data_1_i[63:0]   : 64'h0);
   end

   // Unrolled round datapath; in IDLE it works on the freshly accepted source.
   always_comb begin
      rnd_in_s    = idle_s ? src_s : state_r;
      r_start_s   = idle_s ? (4'd12 - nrounds_i) : round_r;
      post_en_s   = idle_s ? ctrl_2_i : ctrl2_r;
      post_data_s = idle_s ? data_2_i : data2_r;
      rnd_out_s   = rnd_in_s;
      for (int unsigned u = 0; u < UNROLL; u++) begin
         rnd_out_s = ascon_round(rnd_out_s, r_start_s + 4'(u));
      end
      r_next_s    = {1'b0, r_start_s} + 5'(UNROLL);
      last_s      = (r_next_s == 5'd12);
      zero_res_s  = post_xor(src_s, post_en_s, post_data_s);
      round_res_s = last_s ? post_xor(rnd_out_s, post_en_s, post_data_s) : rnd_out_s;
   end

   // Control FSM, round counter, state register and status pulses.
   always_ff @(posedge clock_i) begin
      if (rst_i) begin
         fsm_r   <= ST_IDLE;
         state_r <= RST_STATE;
         round_r <= 4'd0;
         ctrl2_r <= 1'b0;
         data2_r <= 192'h0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (fsm_r)
            ST_IDLE: begin
               if (start_i) begin
                  if (!legal_s) begin
                     err_r <= 1'b1;
                  end else begin
                     ctrl2_r <= ctrl_2_i;
                     data2_r <= data_2_i;
                     if (nrounds_i == 4'd0) begin
                        state_r <= zero_res_s;
                        round_r <= 4'd12;
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= round_res_s;
                        round_r <= r_next_s[3:0];
                        if (last_s) begin
                           done_r <= 1'b1;
                        end else begin
                           fsm_r <= ST_RUN;
                        end
                     end
                  end
               end
            end
            ST_RUN: begin
               state_r <= round_res_s;
               round_r <= r_next_s[3:0];
               if (last_s) begin
                  done_r <= 1'b1;
                  fsm_r  <= ST_IDLE;
               end
            end
            default: begin
               fsm_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready_o  = (fsm_r == ST_IDLE);
   assign done_o   = done_r;
   assign err_o    = err_r;
   assign state_o  = state_r;
   assign cipher_o = {state_r[0], state_r[1]};
   assign tag_o    = {state_r[3], state_r[4]};

endmodule

// File: tb/tb_permutation_xor_unrolled.sv
// Bench for permutation_xor_unrolled: UNROLL=1 and UNROLL=4 instances share stimulus
// and are checked against a table-driven ASCON reference model.
module tb_permutation_xor_unrolled;

   localparam int unsigned UN [2] = '{1, 4};
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   logic         clock_i = 1'b0;
   logic         rst_i, start_i, init_state_i, ctrl_1_i, ctrl_2_i;
   logic [3:0]   nrounds_i;
   logic [319:0] s_in;
   logic [127:0] data_1_i;
   logic [191:0] data_2_i;

   logic [319:0] state_a  [2];
   logic [127:0] cipher_a [2];
   logic [127:0] tag_a    [2];
   logic         ready_a  [2];
   logic         done_a   [2];
   logic         err_a    [2];

   logic [319:0] model [2];
   int checks = 0;
   int failures = 0;

   permutation_xor_unrolled #(.UNROLL(1)) dut1 (
      .clock_i(clock_i), .rst_i(rst_i), .start_i(start_i), .nrounds_i(nrounds_i),
      .init_state_i(init_state_i), .S_i(s_in), .ctrl_1_i(ctrl_1_i), .data_1_i(data_1_i),
      .ctrl_2_i(ctrl_2_i), .data_2_i(data_2_i), .ready_o(ready_a[0]), .done_o(done_a[0]),
      .err_o(err_a[0]), .state_o(state_a[0]), .cipher_o(cipher_a[0]), .tag_o(tag_a[0]));

   permutation_xor_unrolled #(.UNROLL(4)) dut4 (
      .clock_i(clock_i), .rst_i(rst_i), .start_i(start_i), .nrounds_i(nrounds_i),
      .init_state_i(init_state_i), .S_i(s_in), .ctrl_1_i(ctrl_1_i), .data_1_i(data_1_i),
      .ctrl_2_i(ctrl_2_i), .data_2_i(data_2_i), .ready_o(ready_a[1]), .done_o(done_a[1]),
      .err_o(err_a[1]), .state_o(state_a[1]), .cipher_o(cipher_a[1]), .tag_o(tag_a[1]));

   always #5 clock_i = ~clock_i;

   function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x};
      return d[n +: 64];
   endfunction

   // Reference round: constant, S-box applied column by column from the table, diffusion.
   function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  col, o;
      logic [319:0] res;
      for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
      x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
         col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
         o = SBOX[col];
         y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
      end
      for (int i = 0; i < 5; i++)
         res[64*i +: 64] = y[i] ^ m_ror(y[i], ROT_A[i]) ^ m_ror(y[i], ROT_B[i]);
      return res;
   endfunction

   function automatic logic [319:0] m_op(input logic [319:0] src, input int n,
                                         input logic c2, input logic [191:0] d2);
      logic [319:0] s;
      s = src;
      for (int r = 12 - n; r < 12; r++) s = m_round(s, r);
      if (c2) begin
         s[128 +: 64] = s[128 +: 64] ^ d2[191:128];
         s[192 +: 64] = s[192 +: 64] ^ d2[127:64];
         s[256 +: 64] = s[256 +: 64] ^ d2[63:0];
      end
      return s;
   endfunction

   function automatic logic m_legal(input int n, input int u);
      return (n == 0) || ((n == 6 || n == 8 || n == 12) && (n % u == 0));
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] v;
      for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic scramble_inputs();
      s_in         = rnd320();
      data_1_i     = rnd320()[127:0];
      data_2_i     = rnd320()[191:0];
      ctrl_1_i     = 1'($urandom);
      ctrl_2_i     = 1'($urandom);
      init_state_i = 1'($urandom);
   endtask

   // Issues one request, checks every cycle until the slower instance is done.
   task automatic run_op(input int n, input logic init, input logic [319:0] s,
                         input logic c1, input logic [127:0] d1, input logic c2,
                         input logic [191:0] d2, input logic pulse_mid);
      logic [319:0] exp [2];
      logic         lg  [2];
      int           lat [2];
      int           maxlat;
      logic [319:0] src;
      maxlat = 1;
      for (int i = 0; i < 2; i++) begin
         lg[i] = m_legal(n, UN[i]);
         if (lg[i]) begin
            src = init ? s : model[i];
            if (c1) begin
               src[63:0]   = src[63:0]   ^ d1[127:64];
               src[127:64] = src[127:64] ^ d1[63:0];
            end
            exp[i] = m_op(src, n, c2, d2);
            lat[i] = (n == 0) ? 1 : n / int'(UN[i]);
         end else begin
            exp[i] = model[i];
            lat[i] = 1;
         end
         if (lat[i] > maxlat) maxlat = lat[i];
      end
      start_i = 1'b1; nrounds_i = 4'(n); init_state_i = init; s_in = s;
      ctrl_1_i = c1; data_1_i = d1; ctrl_2_i = c2; data_2_i = d2;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      scramble_inputs();
      for (int k = 1; k <= maxlat; k++) begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (done_a[i] !== (lg[i] && k == lat[i])) begin
               failures++;
               $display("FAIL done u%0d n=%0d k=%0d: got %b exp %b", UN[i], n, k, done_a[i], lg[i] && k == lat[i]);
            end
            checks++;
            if (err_a[i] !== (!lg[i] && k == 1)) begin
               failures++;
               $display("FAIL err u%0d n=%0d k=%0d: got %b exp %b", UN[i], n, k, err_a[i], !lg[i] && k == 1);
            end
            checks++;
            if (ready_a[i] !== (k >= lat[i])) begin
               failures++;
               $display("FAIL ready u%0d n=%0d k=%0d: got %b exp %b", UN[i], n, k, ready_a[i], k >= lat[i]);
            end
            if (k == lat[i]) begin
               checks++;
               if (state_a[i] !== exp[i]) begin
                  failures++;
                  $display("FAIL state u%0d n=%0d: got %h exp %h", UN[i], n, state_a[i], exp[i]);
               end
               checks++;
               if (cipher_a[i] !== {exp[i][63:0], exp[i][127:64]} ||
                   tag_a[i] !== {exp[i][255:192], exp[i][319:256]}) begin
                  failures++;
                  $display("FAIL cipher_tag u%0d n=%0d: got %h/%h exp %h/%h", UN[i], n, cipher_a[i], tag_a[i],
                           {exp[i][63:0], exp[i][127:64]}, {exp[i][255:192], exp[i][319:256]});
               end
            end
         end
         if (k < maxlat) begin
            if (pulse_mid && k == 1) begin
               start_i = 1'b1; nrounds_i = 4'd5;
            end
            @(posedge clock_i); #1;
            start_i = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) model[i] = exp[i];
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; nrounds_i = 4'd0;
      scramble_inputs();
      @(posedge clock_i); @(posedge clock_i); #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (state_a[i] !== 320'h0 || ready_a[i] !== 1'b1 || done_a[i] !== 1'b0 || err_a[i] !== 1'b0) begin
            failures++;
            $display("FAIL reset u%0d: got st=%h rdy=%b done=%b err=%b exp 0/1/0/0", UN[i], state_a[i], ready_a[i], done_a[i], err_a[i]);
         end
         model[i] = 320'h0;
      end
      rst_i = 1'b0;
   endtask

   task automatic test_ascon_init();
      logic [319:0] s;
      s = 320'h0;
      s[63:0] = 64'h00001000808C0001;
      run_op(12, 1'b1, s, 1'b0, 128'h0, 1'b1, 192'h0, 1'b0);
   endtask

   task automatic test_pre_xor();
      run_op(8, 1'b0, rnd320(), 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 192'h0, 1'b0);
   endtask

   task automatic test_xor_only();
      run_op(0, 1'b0, rnd320(), 1'b1, rnd320()[127:0], 1'b0, rnd320()[191:0], 1'b0);
      run_op(0, 1'b1, rnd320(), 1'b1, rnd320()[127:0], 1'b1, rnd320()[191:0], 1'b0);
   endtask

   task automatic test_illegal();
      run_op(6, 1'b1, rnd320(), 1'b1, rnd320()[127:0], 1'b1, rnd320()[191:0], 1'b0);
      run_op(5, 1'b1, rnd320(), 1'b0, 128'h0, 1'b0, 192'h0, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_op(12, 1'b1, rnd320(), 1'b1, rnd320()[127:0], 1'b1, rnd320()[191:0], 1'b1);
   endtask

   task automatic test_back_to_back();
      run_op(12, 1'b0, rnd320(), 1'b0, 128'h0, 1'b1, rnd320()[191:0], 1'b0);
      run_op(12, 1'b0, rnd320(), 1'b1, rnd320()[127:0], 1'b0, 192'h0, 1'b0);
      run_op(0, 1'b0, rnd320(), 1'b1, rnd320()[127:0], 1'b1, rnd320()[191:0], 1'b0);
   endtask

   task automatic test_random();
      int ns [8] = '{0, 6, 8, 12, 5, 4, 3, 15};
      for (int t = 0; t < 24; t++)
         run_op(ns[$urandom_range(7, 0)], 1'($urandom), rnd320(), 1'($urandom), rnd320()[127:0],
                1'($urandom), rnd320()[191:0], 1'b0);
   endtask

   task automatic test_mid_reset();
      start_i = 1'b1; nrounds_i = 4'd12; init_state_i = 1'b1; s_in = rnd320();
      ctrl_1_i = 1'b0; ctrl_2_i = 1'b1; data_2_i = rnd320()[191:0];
      @(posedge clock_i); #1;
      start_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if (done_a[0] !== 1'b0 || done_a[1] !== (k == 3)) begin
            failures++;
            $display("FAIL pre_reset_done k=%0d: got %b/%b exp 0/%b", k, done_a[0], done_a[1], k == 3);
         end
         if (k < 5) begin
            @(posedge clock_i); #1;
         end
      end
      rst_i = 1'b1;
      @(posedge clock_i); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (state_a[i] !== 320'h0 || ready_a[i] !== 1'b1 || done_a[i] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset u%0d: got st=%h rdy=%b done=%b exp 0/1/0", UN[i], state_a[i], ready_a[i], done_a[i]);
         end
         model[i] = 320'h0;
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clock_i); #1;
         checks++;
         if (done_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL aborted_done k=%0d: got %b exp 0", k, done_a[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ascon_init();
      test_pre_xor();
      test_xor_only();
      test_illegal();
      test_start_ignored();
      test_back_to_back();
      test_random();
      test_mid_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
